// File: rtl/xilinx_pcie_rate_ctrl.sv
// PCIe Gen1/Gen2 link-rate change sequencer: moves the GT lanes to the new rate,
// gates the PIPE clock, switches the pclk select, ungates and signals phystatus.
module xilinx_pcie_rate_ctrl #(
    parameter int PCIE_LANE   = 2,
    parameter int GATE_CYCLES = 4,
    parameter int SEL_CYCLES  = 8,
    parameter int TIMEOUT     = 1000
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 rate_i,
    input  logic                 mmcm_lock_i,
    input  logic [PCIE_LANE-1:0] lane_rate_done_i,
    output logic                 gt_rate_o,
    output logic [PCIE_LANE-1:0] pclk_sel_o,
    output logic                 pipeclk_en_o,
    output logic                 phystatus_o,
    output logic                 busy_o,
    output logic                 timeout_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT);
    localparam logic [CW-1:0] GATE_LAST = CW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0] SEL_LAST  = CW'(SEL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        GT_RATE,
        CLK_GATE,
        CLK_SEL,
        CLK_UNGATE,
        DONE
    } state_t;

    state_t               state;
    logic                 cur_rate;
    logic                 target_rate;
    logic [PCIE_LANE-1:0] done_mask;
    logic [PCIE_LANE-1:0] mask_next;
    logic [CW-1:0]        wait_cnt;
    logic [CW-1:0]        cnt_inc;
    logic                 all_done;
    logic                 cnt_expired;

    // Done pulses are folded in combinationally so a full mask is acted on
    // the same edge it completes, including pulses in the entry cycle.
    always_comb begin
        mask_next   = done_mask | lane_rate_done_i;
        all_done    = &mask_next;
        cnt_expired = (wait_cnt == CNT_MAX);
        cnt_inc     = cnt_expired ? wait_cnt : wait_cnt + CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            cur_rate     <= 1'b0;
            target_rate  <= 1'b0;
            gt_rate_o    <= 1'b0;
            pclk_sel_o   <= '0;
            pipeclk_en_o <= 1'b1;
            phystatus_o  <= 1'b0;
            busy_o       <= 1'b0;
            timeout_o    <= 1'b0;
            done_mask    <= '0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    phystatus_o <= 1'b0;
                    if ((rate_i != cur_rate) && mmcm_lock_i) begin
                        state       <= GT_RATE;
                        gt_rate_o   <= rate_i;
                        target_rate <= rate_i;
                        done_mask   <= '0;
                        wait_cnt    <= '0;
                        busy_o      <= 1'b1;
                    end
                end

                GT_RATE: begin
                    done_mask <= mask_next;
                    if (all_done || cnt_expired) begin
                        if (!all_done)
                            timeout_o <= 1'b1;
                        state        <= CLK_GATE;
                        pipeclk_en_o <= 1'b0;
                        wait_cnt     <= '0;
                    end else begin
                        wait_cnt <= cnt_inc;
                    end
                end

                CLK_GATE: begin
                    if (wait_cnt == GATE_LAST) begin
                        state      <= CLK_SEL;
                        pclk_sel_o <= {PCIE_LANE{target_rate}};
                        wait_cnt   <= '0;
                    end else begin
                        wait_cnt <= cnt_inc;
                    end
                end

                CLK_SEL: begin
                    if (wait_cnt == SEL_LAST) begin
                        state        <= CLK_UNGATE;
                        pipeclk_en_o <= 1'b1;
                        wait_cnt     <= '0;
                    end else begin
                        wait_cnt <= cnt_inc;
                    end
                end

                // A missing MMCM lock is not fatal: flag it and finish anyway.
                CLK_UNGATE: begin
                    if (mmcm_lock_i || cnt_expired) begin
                        if (!mmcm_lock_i)
                            timeout_o <= 1'b1;
                        state       <= DONE;
                        phystatus_o <= 1'b1;
                        wait_cnt    <= '0;
                    end else begin
                        wait_cnt <= cnt_inc;
                    end
                end

                DONE: begin
                    phystatus_o <= 1'b0;
                    cur_rate    <= target_rate;
                    state       <= IDLE;
                    busy_o      <= 1'b0;
                    wait_cnt    <= '0;
                end

                default: begin
                    state       <= IDLE;
                    phystatus_o <= 1'b0;
                    busy_o      <= 1'b0;
                    wait_cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/xilinx_pcie_rate_ctrl.md
XILINX_PCIE_RATE_CTRL -- requirements
Module: xilinx_pcie_rate_ctrl

Interface
REQ-001 SHALL have parameter PCIE_LANE, default 2: number of PCIe lanes.
REQ-002 SHALL have parameter GATE_CYCLES, default 4: cycles pipeclk held gated before the select change.
REQ-003 SHALL have parameter SEL_CYCLES, default 8: cycles held after the select change before ungating.
REQ-004 SHALL have parameter TIMEOUT, default 1000: maximum wait cycles in any wait state.
REQ-005 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n_i, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port rate_i, input, 1: requested link rate (0 = 2.5 GT/s, 1 = 5 GT/s).
REQ-008 SHALL have port mmcm_lock_i, input, 1: PIPE clock MMCM lock.
REQ-009 SHALL have port lane_rate_done_i, input, PCIE_LANE: per-lane GT rate-change-done pulse.
REQ-010 SHALL have port gt_rate_o, output, 1: rate driven to the GT lanes.
REQ-011 SHALL have port pclk_sel_o, output, PCIE_LANE: per-lane pclk select to the clock MMCM block (1 = 250 MHz).
REQ-012 SHALL have port pipeclk_en_o, output, 1: pclk/dclk buffer clock enable.
REQ-013 SHALL have port phystatus_o, output, 1: one-cycle completion pulse to the PCIe core.
REQ-014 SHALL have port busy_o, output, 1: high whenever state is not IDLE.
REQ-015 SHALL have port timeout_o, output, 1: sticky timeout flag.

Function
REQ-016 SHALL implement states IDLE, GT_RATE, CLK_GATE, CLK_SEL, CLK_UNGATE, DONE.
REQ-017 SHALL keep internal cur_rate; in IDLE, when rate_i != cur_rate and mmcm_lock_i = 1, SHALL enter GT_RATE on the next edge; otherwise stay in IDLE.
REQ-018 SHALL, on GT_RATE entry, set gt_rate_o = rate_i, latch the target rate, clear the per-lane done mask and the wait counter.
REQ-019 SHALL, in GT_RATE, OR lane_rate_done_i into the done mask every cycle (pulses on different cycles accumulate; repeated pulses harmless).
REQ-020 SHALL leave GT_RATE for CLK_GATE on the cycle after the mask becomes all-ones, including when all lanes pulse in the entry cycle.
REQ-021 SHALL drive pipeclk_en_o = 0 from CLK_GATE entry; stay GATE_CYCLES cycles, then enter CLK_SEL.
REQ-022 SHALL, on CLK_SEL entry, set every bit of pclk_sel_o to the target rate simultaneously; stay SEL_CYCLES cycles, then enter CLK_UNGATE.
REQ-023 SHALL drive pipeclk_en_o = 1 from CLK_UNGATE entry and wait for mmcm_lock_i = 1, then enter DONE.
REQ-024 SHALL, in DONE, assert phystatus_o for exactly one cycle, set cur_rate = target rate, and return to IDLE next cycle.
REQ-025 SHALL ignore rate_i changes while not in IDLE; a mismatch remaining on return to IDLE starts a new sequence no earlier than one cycle after DONE.
REQ-026 SHALL, when the wait counter in GT_RATE or CLK_UNGATE reaches TIMEOUT, set timeout_o and advance to the next state as if the condition had been met.
REQ-027 SHALL size the wait counter to $clog2(TIMEOUT+1) bits, saturating, and clear it on every state entry.
REQ-028 SHALL clear timeout_o only by reset.
REQ-029 SHALL never drive pclk_sel_o to a mixed value except during reset release; all bits always equal.

Reset
REQ-030 SHALL, while rst_n_i = 0 at an edge, set state IDLE, cur_rate 0, gt_rate_o 0, pclk_sel_o all 0, pipeclk_en_o 1, phystatus_o 0, busy_o 0, timeout_o 0, mask and counter 0.
REQ-031 SHALL abort any in-progress sequence on reset with no phystatus_o pulse.

Verification
REQ-032 Gen1->Gen2 (PCIE_LANE=2): rate_i 0->1, lock=1, lane done pulses 3 cycles apart -> gt_rate_o=1, pipeclk_en_o low exactly 4+8 cycles, pclk_sel_o=2'b11, one phystatus_o pulse, timeout_o=0.
REQ-033 Gen2->Gen1 after REQ-032: rate_i 1->0 -> pclk_sel_o=2'b00 after gating, single phystatus_o pulse, busy_o low after DONE.
REQ-034 Lane 1 never reports done -> timeout_o=1 after 1000 cycles in GT_RATE, sequence completes, phystatus_o pulses once.
REQ-035 rate_i toggles 1->0 during CLK_SEL -> first sequence completes to rate 1, second sequence back to 0 starts after DONE.
REQ-036 rst_n_i=0 for one cycle during CLK_GATE -> pipeclk_en_o=1, pclk_sel_o=0, no phystatus_o pulse; if rate_i=1, new sequence starts once mmcm_lock_i=1.
REQ-037 mmcm_lock_i=0 while rate_i mismatches in IDLE -> no state change until lock asserts.
